// File: rtl/sc_shiftctrl_if.sv
// sc_shiftctrl_if
// Command and shift-register bus between the upstream command source and the
// sc_shiftctrl sequencer.
//
//   master : command source (drives start/direction/shiftcount/data/abort,
//            observes ready/done and the shift-register strobes)
//   slave  : sc_shiftctrl (consumes the command, drives the strobes)
//
// Signals
//   SC_SHIFTCTRL_start_InHigh        command valid
//   SC_SHIFTCTRL_direction_In        0 = left (selection 01), 1 = right (10)
//   SC_SHIFTCTRL_shiftcount_In       requested single-bit shifts
//   SC_SHIFTCTRL_data_InBUS          word to load
//   SC_SHIFTCTRL_abort_InHigh        cancel operation in progress
//   SC_SHIFTCTRL_clear_OutLow        shift register clear (active low)
//   SC_SHIFTCTRL_load_OutLow         shift register load (active low)
//   SC_SHIFTCTRL_shiftselection_Out  shift register 2-bit selection
//   SC_SHIFTCTRL_data_OutBUS         shift register data input
//   SC_SHIFTCTRL_ready_OutHigh       command can be accepted
//   SC_SHIFTCTRL_done_OutHigh        one-cycle completion pulse
//   SC_SHIFTCTRL_remain_OutBUS       shifts still to issue (only with
//                                    SHIFTCTRL_REMAIN_EN defined)
interface sc_shiftctrl_if #(
   parameter int SHIFTCTRL_DATAWIDTH  = 8,
   parameter int SHIFTCTRL_COUNTWIDTH = 4
);
   logic                            SC_SHIFTCTRL_start_InHigh;
   logic                            SC_SHIFTCTRL_direction_In;
   logic [SHIFTCTRL_COUNTWIDTH-1:0] SC_SHIFTCTRL_shiftcount_In;
   logic [SHIFTCTRL_DATAWIDTH-1:0]  SC_SHIFTCTRL_data_InBUS;
   logic                            SC_SHIFTCTRL_abort_InHigh;
   logic                            SC_SHIFTCTRL_clear_OutLow;
   logic                            SC_SHIFTCTRL_load_OutLow;
   logic [1:0]                      SC_SHIFTCTRL_shiftselection_Out;
   logic [SHIFTCTRL_DATAWIDTH-1:0]  SC_SHIFTCTRL_data_OutBUS;
   logic                            SC_SHIFTCTRL_ready_OutHigh;
   logic                            SC_SHIFTCTRL_done_OutHigh;
`ifdef SHIFTCTRL_REMAIN_EN
   logic [SHIFTCTRL_COUNTWIDTH-1:0] SC_SHIFTCTRL_remain_OutBUS;

   modport master (
      output SC_SHIFTCTRL_start_InHigh, SC_SHIFTCTRL_direction_In,
             SC_SHIFTCTRL_shiftcount_In, SC_SHIFTCTRL_data_InBUS,
             SC_SHIFTCTRL_abort_InHigh,
      input  SC_SHIFTCTRL_clear_OutLow, SC_SHIFTCTRL_load_OutLow,
             SC_SHIFTCTRL_shiftselection_Out, SC_SHIFTCTRL_data_OutBUS,
             SC_SHIFTCTRL_ready_OutHigh, SC_SHIFTCTRL_done_OutHigh,
             SC_SHIFTCTRL_remain_OutBUS
   );

   modport slave (
      input  SC_SHIFTCTRL_start_InHigh, SC_SHIFTCTRL_direction_In,
             SC_SHIFTCTRL_shiftcount_In, SC_SHIFTCTRL_data_InBUS,
             SC_SHIFTCTRL_abort_InHigh,
      output SC_SHIFTCTRL_clear_OutLow, SC_SHIFTCTRL_load_OutLow,
             SC_SHIFTCTRL_shiftselection_Out, SC_SHIFTCTRL_data_OutBUS,
             SC_SHIFTCTRL_ready_OutHigh, SC_SHIFTCTRL_done_OutHigh,
             SC_SHIFTCTRL_remain_OutBUS
   );
`else
   modport master (
      output SC_SHIFTCTRL_start_InHigh, SC_SHIFTCTRL_direction_In,
             SC_SHIFTCTRL_shiftcount_In, SC_SHIFTCTRL_data_InBUS,
             SC_SHIFTCTRL_abort_InHigh,
      input  SC_SHIFTCTRL_clear_OutLow, SC_SHIFTCTRL_load_OutLow,
             SC_SHIFTCTRL_shiftselection_Out, SC_SHIFTCTRL_data_OutBUS,
             SC_SHIFTCTRL_ready_OutHigh, SC_SHIFTCTRL_done_OutHigh
   );

   modport slave (
      input  SC_SHIFTCTRL_start_InHigh, SC_SHIFTCTRL_direction_In,
             SC_SHIFTCTRL_shiftcount_In, SC_SHIFTCTRL_data_InBUS,
             SC_SHIFTCTRL_abort_InHigh,
      output SC_SHIFTCTRL_clear_OutLow, SC_SHIFTCTRL_load_OutLow,
             SC_SHIFTCTRL_shiftselection_Out, SC_SHIFTCTRL_data_OutBUS,
             SC_SHIFTCTRL_ready_OutHigh, SC_SHIFTCTRL_done_OutHigh
   );
`endif
endinterface

// File: rtl/sc_shiftctrl.sv
// sc_shiftctrl
// Sequencer sitting directly upstream of a shift register. Accepts a word and
// a shift command (direction, count), then drives the register's clear, load,
// shift-selection and data inputs cycle by cycle and pulses done when the
// register holds the final value. The register output is the result; this
// block only keeps the latched word.
//
// Ports
//   SC_SHIFTCTRL_CLOCK_50       system clock, rising edge
//   SC_SHIFTCTRL_RESET_InHigh   synchronous active-high reset
//   scBus (slave)               command handshake and shift-register strobes,
//                               see sc_shiftctrl_if
//
// Parameters
//   SHIFTCTRL_DATAWIDTH   loaded word width (equals the shift register width)
//   SHIFTCTRL_COUNTWIDTH  shift-count width; 2**COUNTWIDTH must exceed
//                         DATAWIDTH so the clamp value is representable
//
// Optional feature macro: SHIFTCTRL_REMAIN_EN adds the remain count output.
//
// Every output is a flop written by the FSM, so nothing combinational runs
// from inputs to outputs.
module sc_shiftctrl #(
   parameter int SHIFTCTRL_DATAWIDTH  = 8,
   parameter int SHIFTCTRL_COUNTWIDTH = 4
) (
   input logic           SC_SHIFTCTRL_CLOCK_50,
   input logic           SC_SHIFTCTRL_RESET_InHigh,
   sc_shiftctrl_if.slave scBus
);

   localparam logic [SHIFTCTRL_COUNTWIDTH-1:0] maxCount =
      SHIFTCTRL_COUNTWIDTH'(SHIFTCTRL_DATAWIDTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE,
      CLEAR
   } stateT;

   stateT                           state;
   logic [SHIFTCTRL_COUNTWIDTH-1:0] counter;
   logic [SHIFTCTRL_DATAWIDTH-1:0]  dataLatch;
   logic                            dirLatch;
   logic                            clearN;
   logic                            loadN;
   logic [1:0]                      selection;
   logic                            readyReg;
   logic                            doneReg;

   logic [SHIFTCTRL_COUNTWIDTH-1:0] clampedCount;
   logic [1:0]                      dirSelection;

   // Shifting more than the word width cannot change the result further,
   // so the count is saturated at DATAWIDTH on accept.
   assign clampedCount = (scBus.SC_SHIFTCTRL_shiftcount_In > maxCount) ?
                         maxCount : scBus.SC_SHIFTCTRL_shiftcount_In;
   assign dirSelection = dirLatch ? 2'b10 : 2'b01;

   always_ff @(posedge SC_SHIFTCTRL_CLOCK_50) begin
      if (SC_SHIFTCTRL_RESET_InHigh) begin
         state     <= IDLE;
         counter   <= '0;
         dataLatch <= '0;
         dirLatch  <= 1'b0;
         clearN    <= 1'b1;
         loadN     <= 1'b1;
         selection <= 2'b00;
         readyReg  <= 1'b1;
         doneReg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // abort is deliberately not looked at here: start wins.
               if (scBus.SC_SHIFTCTRL_start_InHigh) begin
                  dataLatch <= scBus.SC_SHIFTCTRL_data_InBUS;
                  dirLatch  <= scBus.SC_SHIFTCTRL_direction_In;
                  counter   <= clampedCount;
                  loadN     <= 1'b0;
                  readyReg  <= 1'b0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               loadN <= 1'b1;
               if (scBus.SC_SHIFTCTRL_abort_InHigh) begin
                  counter <= '0;
                  clearN  <= 1'b0;
                  state   <= CLEAR;
               end else if (counter == '0) begin
                  doneReg <= 1'b1;
                  state   <= DONE;
               end else begin
                  selection <= dirSelection;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               // counter holds the shifts left including this cycle, so a
               // value of 1 marks the final shift.
               if (scBus.SC_SHIFTCTRL_abort_InHigh) begin
                  counter   <= '0;
                  selection <= 2'b00;
                  clearN    <= 1'b0;
                  state     <= CLEAR;
               end else begin
                  counter <= counter - 1'b1;
                  if (counter == SHIFTCTRL_COUNTWIDTH'(1)) begin
                     selection <= 2'b00;
                     doneReg   <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               doneReg  <= 1'b0;
               readyReg <= 1'b1;
               state    <= IDLE;
            end
            CLEAR: begin
               clearN   <= 1'b1;
               readyReg <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               clearN    <= 1'b1;
               loadN     <= 1'b1;
               selection <= 2'b00;
               doneReg   <= 1'b0;
               readyReg  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign scBus.SC_SHIFTCTRL_clear_OutLow       = clearN;
   assign scBus.SC_SHIFTCTRL_load_OutLow        = loadN;
   assign scBus.SC_SHIFTCTRL_shiftselection_Out = selection;
   assign scBus.SC_SHIFTCTRL_data_OutBUS        = dataLatch;
   assign scBus.SC_SHIFTCTRL_ready_OutHigh      = readyReg;
   assign scBus.SC_SHIFTCTRL_done_OutHigh       = doneReg;

`ifdef SHIFTCTRL_REMAIN_EN
   logic [SHIFTCTRL_COUNTWIDTH-1:0] remainReg;

   // Tracks what counter will hold in the next LOAD/SHIFT cycle and reads
   // zero everywhere else.
   always_ff @(posedge SC_SHIFTCTRL_CLOCK_50) begin
      if (SC_SHIFTCTRL_RESET_InHigh) begin
         remainReg <= '0;
      end else begin
         case (state)
            IDLE:    remainReg <= scBus.SC_SHIFTCTRL_start_InHigh ? clampedCount : '0;
            LOAD:    remainReg <= (scBus.SC_SHIFTCTRL_abort_InHigh || counter == '0) ?
                                  '0 : counter;
            SHIFT:   remainReg <= scBus.SC_SHIFTCTRL_abort_InHigh ? '0 : counter - 1'b1;
            default: remainReg <= '0;
         endcase
      end
   end

   assign scBus.SC_SHIFTCTRL_remain_OutBUS = remainReg;
`endif

endmodule

// File: tb/tb_sc_shiftctrl.sv
// tb_sc_shiftctrl
// Self-checking bench for sc_shiftctrl. A behavioural shift register is
// driven by the DUT strobes; expected strobe timing and the final register
// value come from the command (data, direction, clamped count) alone.
module tb_sc_shiftctrl;

   localparam int DW = 8;
   localparam int CW = 4;

   logic SC_SHIFTCTRL_CLOCK_50 = 1'b0;
   logic SC_SHIFTCTRL_RESET_InHigh;

   int compareCount  = 0;
   int mismatchCount = 0;
   logic [DW-1:0] lastData = '0;

   sc_shiftctrl_if #(
      .SHIFTCTRL_DATAWIDTH (DW),
      .SHIFTCTRL_COUNTWIDTH(CW)
   ) scBus ();

   sc_shiftctrl #(
      .SHIFTCTRL_DATAWIDTH (DW),
      .SHIFTCTRL_COUNTWIDTH(CW)
   ) dut (
      .SC_SHIFTCTRL_CLOCK_50    (SC_SHIFTCTRL_CLOCK_50),
      .SC_SHIFTCTRL_RESET_InHigh(SC_SHIFTCTRL_RESET_InHigh),
      .scBus                    (scBus.slave)
   );

   always #10 SC_SHIFTCTRL_CLOCK_50 = ~SC_SHIFTCTRL_CLOCK_50;

   // Downstream shift register: clear beats load beats shift, zero fill.
   logic [DW-1:0] shiftReg = '0;
   always @(posedge SC_SHIFTCTRL_CLOCK_50) begin
      if (!scBus.SC_SHIFTCTRL_clear_OutLow)
         shiftReg <= '0;
      else if (!scBus.SC_SHIFTCTRL_load_OutLow)
         shiftReg <= scBus.SC_SHIFTCTRL_data_OutBUS;
      else if (scBus.SC_SHIFTCTRL_shiftselection_Out == 2'b01)
         shiftReg <= shiftReg << 1;
      else if (scBus.SC_SHIFTCTRL_shiftselection_Out == 2'b10)
         shiftReg <= shiftReg >> 1;
   end

   // {clear_n, load_n, selection, ready, done, data}
   logic [DW+5:0] obsVec;
   assign obsVec = {scBus.SC_SHIFTCTRL_clear_OutLow, scBus.SC_SHIFTCTRL_load_OutLow,
                    scBus.SC_SHIFTCTRL_shiftselection_Out, scBus.SC_SHIFTCTRL_ready_OutHigh,
                    scBus.SC_SHIFTCTRL_done_OutHigh, scBus.SC_SHIFTCTRL_data_OutBUS};

   function automatic logic [DW+5:0] pack(input logic clrN, input logic ldN,
                                          input logic [1:0] sel, input logic rdy,
                                          input logic dn, input logic [DW-1:0] d);
      return {clrN, ldN, sel, rdy, dn, d};
   endfunction

   task automatic nextCycle();
      @(posedge SC_SHIFTCTRL_CLOCK_50);
      @(negedge SC_SHIFTCTRL_CLOCK_50);
   endtask

   // Issues one command in the current (idle) cycle and checks every cycle
   // until the block is idle again. abortAt > 0 raises abort during that
   // cycle after accept (1 = load cycle, 2.. = shift cycles).
   task automatic do_cmd(input logic [DW-1:0] data, input logic dir,
                         input logic [CW-1:0] cnt, input int abortAt,
                         input bit holdStart, input string tag);
      int k;
      int expRemain;
      bit finished;
      logic [1:0] selCode;
      logic [DW-1:0] expReg;
      logic [DW+5:0] expV;
      k       = (int'(cnt) > DW) ? DW : int'(cnt);
      selCode = dir ? 2'b10 : 2'b01;
      expReg  = dir ? (data >> k) : (data << k);
      scBus.SC_SHIFTCTRL_start_InHigh  = 1'b1;
      scBus.SC_SHIFTCTRL_data_InBUS    = data;
      scBus.SC_SHIFTCTRL_direction_In  = dir;
      scBus.SC_SHIFTCTRL_shiftcount_In = cnt;
      scBus.SC_SHIFTCTRL_abort_InHigh  = 1'($urandom_range(0, 1));
      finished = 1'b0;
      for (int j = 1; j <= k + 3 && !finished; j++) begin
         nextCycle();
         expRemain = 0;
         if (abortAt > 0 && j == abortAt + 1) begin
            expV = pack(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, data);
         end else if (abortAt > 0 && j == abortAt + 2) begin
            expV = pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, data);
            finished = 1'b1;
         end else if (j == 1) begin
            expV = pack(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, data);
            expRemain = k;
         end else if (j <= k + 1) begin
            expV = pack(1'b1, 1'b1, selCode, 1'b0, 1'b0, data);
            expRemain = k - (j - 2);
         end else if (j == k + 2) begin
            expV = pack(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, data);
         end else begin
            expV = pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, data);
            finished = 1'b1;
         end
         compareCount++;
         if (obsVec !== expV) begin
            mismatchCount++;
            $display("FAIL %s cycle %0d strobes {clrN,ldN,sel,rdy,done,data}: got %h expected %h",
                     tag, j, obsVec, expV);
         end
`ifdef SHIFTCTRL_REMAIN_EN
         compareCount++;
         if (scBus.SC_SHIFTCTRL_remain_OutBUS !== CW'(expRemain)) begin
            mismatchCount++;
            $display("FAIL %s cycle %0d remain: got %0d expected %0d",
                     tag, j, scBus.SC_SHIFTCTRL_remain_OutBUS, expRemain);
         end
`endif
         if (abortAt <= 0 && j == k + 2) begin
            compareCount++;
            if (shiftReg !== expReg) begin
               mismatchCount++;
               $display("FAIL %s register at done: got %h expected %h", tag, shiftReg, expReg);
            end
         end
         if (abortAt > 0 && j == abortAt + 2) begin
            compareCount++;
            if (shiftReg !== '0) begin
               mismatchCount++;
               $display("FAIL %s register after abort: got %h expected 00", tag, shiftReg);
            end
         end
         if (finished) begin
            scBus.SC_SHIFTCTRL_start_InHigh = 1'b0;
            scBus.SC_SHIFTCTRL_abort_InHigh = 1'b0;
         end else begin
            scBus.SC_SHIFTCTRL_start_InHigh  = holdStart;
            scBus.SC_SHIFTCTRL_data_InBUS    = DW'($urandom);
            scBus.SC_SHIFTCTRL_direction_In  = 1'($urandom);
            scBus.SC_SHIFTCTRL_shiftcount_In = CW'($urandom);
            if (j == abortAt)
               scBus.SC_SHIFTCTRL_abort_InHigh = 1'b1;
            else if ((abortAt <= 0 && j == k + 2) || (abortAt > 0 && j == abortAt + 1))
               scBus.SC_SHIFTCTRL_abort_InHigh = 1'($urandom_range(0, 1));
            else
               scBus.SC_SHIFTCTRL_abort_InHigh = 1'b0;
         end
      end
      lastData = data;
   endtask

   task automatic test_reset();
      SC_SHIFTCTRL_RESET_InHigh = 1'b1;
      scBus.SC_SHIFTCTRL_start_InHigh  = 1'b1;
      scBus.SC_SHIFTCTRL_abort_InHigh  = 1'b1;
      scBus.SC_SHIFTCTRL_direction_In  = 1'b1;
      scBus.SC_SHIFTCTRL_shiftcount_In = 4'd5;
      scBus.SC_SHIFTCTRL_data_InBUS    = 8'hFF;
      repeat (2) nextCycle();
      compareCount++;
      if (obsVec !== pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00)) begin
         mismatchCount++;
         $display("FAIL reset_values: got %h expected %h", obsVec,
                  pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00));
      end
`ifdef SHIFTCTRL_REMAIN_EN
      compareCount++;
      if (scBus.SC_SHIFTCTRL_remain_OutBUS !== '0) begin
         mismatchCount++;
         $display("FAIL reset_remain: got %0d expected 0", scBus.SC_SHIFTCTRL_remain_OutBUS);
      end
`endif
      SC_SHIFTCTRL_RESET_InHigh = 1'b0;
      scBus.SC_SHIFTCTRL_start_InHigh = 1'b0;
      scBus.SC_SHIFTCTRL_abort_InHigh = 1'b0;
      nextCycle();
      compareCount++;
      if (obsVec !== pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00)) begin
         mismatchCount++;
         $display("FAIL idle_after_reset: got %h expected %h", obsVec,
                  pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00));
      end
      lastData = '0;
   endtask

   task automatic test_directed();
      do_cmd(8'hB4, 1'b0, 4'd2, -1, 1'b0, "left_b4_2");
      do_cmd(8'hB4, 1'b1, 4'd3, -1, 1'b0, "right_b4_3");
      do_cmd(8'h5A, 1'b0, 4'd0, -1, 1'b0, "count_zero");
      do_cmd(8'hC7, 1'b0, 4'd15, -1, 1'b0, "clamp_left_15");
      do_cmd(8'h9E, 1'b1, 4'd9, -1, 1'b0, "clamp_right_9");
      do_cmd(8'h81, 1'b1, 4'd8, -1, 1'b0, "exact_width");
   endtask

   task automatic test_abort();
      do_cmd(8'hE7, 1'b0, 4'd4, 3, 1'b0, "abort_2nd_shift");
      do_cmd(8'h3D, 1'b1, 4'd5, 1, 1'b0, "abort_in_load");
      do_cmd(8'h66, 1'b1, 4'd3, 4, 1'b0, "abort_last_shift");
   endtask

   task automatic test_start_held_reset();
      do_cmd(8'hC3, 1'b1, 4'd4, -1, 1'b1, "held_start");
      scBus.SC_SHIFTCTRL_start_InHigh  = 1'b1;
      scBus.SC_SHIFTCTRL_data_InBUS    = 8'h3C;
      scBus.SC_SHIFTCTRL_direction_In  = 1'b0;
      scBus.SC_SHIFTCTRL_shiftcount_In = 4'd6;
      scBus.SC_SHIFTCTRL_abort_InHigh  = 1'b0;
      nextCycle();
      compareCount++;
      if (obsVec !== pack(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h3C)) begin
         mismatchCount++;
         $display("FAIL midreset_load: got %h expected %h", obsVec,
                  pack(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h3C));
      end
      repeat (2) nextCycle();
      compareCount++;
      if (obsVec !== pack(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h3C)) begin
         mismatchCount++;
         $display("FAIL midreset_shift: got %h expected %h", obsVec,
                  pack(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h3C));
      end
      SC_SHIFTCTRL_RESET_InHigh = 1'b1;
      nextCycle();
      compareCount++;
      if (obsVec !== pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00)) begin
         mismatchCount++;
         $display("FAIL midreset_values: got %h expected %h", obsVec,
                  pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00));
      end
      SC_SHIFTCTRL_RESET_InHigh = 1'b0;
      scBus.SC_SHIFTCTRL_start_InHigh = 1'b0;
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         compareCount++;
         if (obsVec !== pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00)) begin
            mismatchCount++;
            $display("FAIL postreset_idle cycle %0d: got %h expected %h", i, obsVec,
                     pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00));
         end
`ifdef SHIFTCTRL_REMAIN_EN
         compareCount++;
         if (scBus.SC_SHIFTCTRL_remain_OutBUS !== '0) begin
            mismatchCount++;
            $display("FAIL postreset_remain cycle %0d: got %0d expected 0", i,
                     scBus.SC_SHIFTCTRL_remain_OutBUS);
         end
`endif
      end
      lastData = '0;
   endtask

   task automatic test_back_to_back();
      do_cmd(8'h12, 1'b0, 4'd1, -1, 1'b0, "b2b_first");
      do_cmd(8'hA5, 1'b1, 4'd2, -1, 1'b1, "b2b_second");
      do_cmd(8'h7F, 1'b0, 4'd0, -1, 1'b0, "b2b_third");
      do_cmd(8'hF0, 1'b1, 4'd4, 2, 1'b0, "b2b_abort");
      do_cmd(8'h0F, 1'b0, 4'd3, -1, 1'b0, "b2b_after_abort");
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic dr;
      int k;
      int ab;
      int gap;
      for (int n = 0; n < 30; n++) begin
         d  = DW'($urandom);
         c  = CW'($urandom);
         dr = 1'($urandom);
         k  = (int'(c) > DW) ? DW : int'(c);
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, k + 1)) : -1;
         do_cmd(d, dr, c, ab, 1'($urandom), "random_cmd");
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            scBus.SC_SHIFTCTRL_abort_InHigh = 1'($urandom);
            scBus.SC_SHIFTCTRL_data_InBUS   = DW'($urandom);
            nextCycle();
            compareCount++;
            if (obsVec !== pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, lastData)) begin
               mismatchCount++;
               $display("FAIL random_idle_gap: got %h expected %h", obsVec,
                        pack(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, lastData));
            end
         end
         scBus.SC_SHIFTCTRL_abort_InHigh = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      SC_SHIFTCTRL_RESET_InHigh        = 1'b1;
      scBus.SC_SHIFTCTRL_start_InHigh  = 1'b0;
      scBus.SC_SHIFTCTRL_abort_InHigh  = 1'b0;
      scBus.SC_SHIFTCTRL_direction_In  = 1'b0;
      scBus.SC_SHIFTCTRL_shiftcount_In = '0;
      scBus.SC_SHIFTCTRL_data_InBUS    = '0;
      test_reset();
      test_directed();
      test_abort();
      test_start_held_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/sc_shiftctrl.md
Name: sc_shiftctrl

Overview:
- Control stage directly upstream of the shift register. Accepts a word plus a shift command (direction, count) over a start/ready handshake.
- Sequences the register's active-low clear, active-low load, 2-bit shift-selection and data bus cycle by cycle.
- Reports completion with a one-cycle done pulse. The shift register's output is the result, so this block holds no data path beyond one latched word.

Parameters:
- SHIFTCTRL_DATAWIDTH, 8, width of loaded word; must equal the shift register's data width.
- SHIFTCTRL_COUNTWIDTH, 4, width of shift-count input; must satisfy 2^COUNTWIDTH > DATAWIDTH.

Ports:
- SC_SHIFTCTRL_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_SHIFTCTRL_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_SHIFTCTRL_start_InHigh  in  1  command valid.
- SC_SHIFTCTRL_direction_In  in  1  0 = shift left (selection 01), 1 = shift right (selection 10).
- SC_SHIFTCTRL_shiftcount_In  in  COUNTWIDTH  number of single-bit shifts requested.
- SC_SHIFTCTRL_data_InBUS  in  DATAWIDTH  word to load.
- SC_SHIFTCTRL_abort_InHigh  in  1  cancel the operation in progress.
- SC_SHIFTCTRL_clear_OutLow  out  1  to shift register clear.
- SC_SHIFTCTRL_load_OutLow  out  1  to shift register load.
- SC_SHIFTCTRL_shiftselection_Out  out  2  to shift register shift selection.
- SC_SHIFTCTRL_data_OutBUS  out  DATAWIDTH  to shift register data input.
- SC_SHIFTCTRL_ready_OutHigh  out  1  block can accept a command.
- SC_SHIFTCTRL_done_OutHigh  out  1  one-cycle completion pulse.

Behaviour:
- Single clock. Reset is synchronous and active-high; it is sampled only on the rising clock edge.
- Reset:
  - state = IDLE, counter = 0, latched data = 0, latched direction = 0.
  - Outputs: clear_OutLow = 1, load_OutLow = 1, shiftselection = 00, data_OutBUS = 0, ready = 1, done = 0.
  - Reset overrides every other input, including mid-operation. No done pulse is issued.
- All outputs are decoded from registered state only (Moore); there are no combinational input-to-output paths.
- States: IDLE, LOAD, SHIFT, DONE, CLEAR.
- IDLE:
  - ready = 1, all strobes inactive, shiftselection = 00.
  - Command is accepted when start = 1 and ready = 1.
  - On accept, latch data, direction and count. Count is clamped to DATAWIDTH if larger. Next state is LOAD.
- LOAD:
  - load_OutLow = 0 and data_OutBUS = latched word for exactly one cycle.
  - Next state is DONE if count == 0, else SHIFT.
- SHIFT:
  - shiftselection = 01 (direction 0) or 10 (direction 1) every cycle; counter decrements each cycle.
  - Exactly count cycles are spent in SHIFT; leave to DONE on the cycle the counter reaches 1.
- DONE: done = 1 for one cycle, shiftselection = 00, then IDLE.
- CLEAR: clear_OutLow = 0 for one cycle, then IDLE. No done pulse.
- ready = 1 only in IDLE. start in any other state is ignored and not queued.
- Latency, for a command accepted at the edge ending cycle N with count k:
  - load at cycle N+1;
  - shifts at cycles N+2 .. N+1+k;
  - done at cycle N+2+k.
  - The downstream register holds the final value when done is high.
  - Back-to-back: the next start is accepted in the cycle after DONE.
- Abort:
  - Effective only in LOAD or SHIFT; next state is CLEAR. The counter is zeroed.
  - Ignored in IDLE, DONE and CLEAR.
  - abort and start together in IDLE: start is accepted.
- data_OutBUS holds the latched word at all times after the first accept; the register ignores it unless load is low.
- Width rules: counter is COUNTWIDTH bits. Clamp compare is done at COUNTWIDTH width; the counter never wraps.

Optional Feature:
- SHIFTCTRL_REMAIN_EN
- Defined:
  - Adds output port SC_SHIFTCTRL_remain_OutBUS (COUNTWIDTH bits) carrying the number of shifts still to be issued, including the current cycle.
  - Its value is the clamped count during LOAD, counts down k..1 during SHIFT, and is 0 in IDLE, DONE and CLEAR. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then data 8'hB4, count 2, direction 0, start one cycle → load low one cycle with data B4, selection 01 for 2 cycles, done one cycle later; register reads 8'hD0 at done.
- Same with direction 1, count 3 → selection 10 for 3 cycles; register reads 8'h16 at done; ready returns to 1 the cycle after done.
- count 0, data 8'h5A → load, then done the next cycle with no shift cycles; register reads 5A.
- count 15 with DATAWIDTH 8 → clamped to 8 shift cycles; register reads 0 at done.
- Abort during the 2nd of 4 shifts → clear_OutLow low one cycle, no done, ready = 1 next cycle; register reads 0.
- start held high during an operation, plus reset asserted mid-SHIFT → extra starts ignored; after reset all outputs are at reset values and no done pulse occurs.
